// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path.
//   - opcode constants (IR[31:26])
//   - control FSM state encoding
//   - ALU operation, ALU B-source and PC-source codes
package mips_pkg;

  localparam int STATE_BITS = 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [1:0] ALUSRCB_RT     = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALURES = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Encodings 13..15 are unused and recover to S_FETCH.
  typedef enum logic [STATE_BITS-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ORIEX   = 4'd10,
    S_IMMWB   = 4'd11,
    S_JUMP    = 4'd12
  } state_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// State -> datapath control decode for the multicycle controller.
// Purely combinational; every output defaults to 0 and is raised only
// in the states that use it.
//   state       in  current FSM state
//   mem_ready   in  memory completes access this cycle (gates IR/PC load in FETCH)
//   zero        in  ALU zero flag (branch decision)
//   op          in  opcode, distinguishes beq from bne in BRANCH
//   pcen..aluop out datapath enables / selects
module mc_ctrl_outdec
  import mips_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  input  logic       zero,
  input  logic [5:0] op,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop
);

  logic pcwrite;
  logic branch;
  logic bne;

  always_comb begin
    pcwrite  = 1'b0;
    branch   = 1'b0;
    bne      = 1'b0;
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = ALUSRCB_RT;
    pcsrc    = PCSRC_ALURES;
    aluop    = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        // PC+4 and IR load only on the cycle the fetch actually completes
        alusrcb = ALUSRCB_FOUR;
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      S_DECODE: begin
        // precompute branch target into ALUOut
        alusrcb = ALUSRCB_IMMSH2;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = ALUSRCB_IMM;
      end
      S_MEMRD: begin
        iord = 1'b1;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = PCSRC_ALUOUT;
        branch  = 1'b1;
        bne     = (op == OP_BNE);
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = ALUSRCB_IMM;
      end
      S_ORIEX: begin
        alusrca = 1'b1;
        alusrcb = ALUSRCB_IMM;
        aluop   = ALUOP_OR;
      end
      S_IMMWB: begin
        regwrite = 1'b1;
      end
      S_JUMP: begin
        pcsrc   = PCSRC_JUMP;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  // bne inverts the sense of the zero flag
  assign pcen = pcwrite | (branch & (zero ^ bne));

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: sequences shared memory, register file and
// ALU over several cycles per instruction. Holds the state register and
// next-state logic; output decode lives in mc_ctrl_outdec.
//   clk, reset   clock, synchronous active-high reset (forces FETCH)
//   op           opcode IR[31:26], sampled in DECODE and MEMADR
//   zero         ALU zero flag
//   mem_ready    memory completes access this cycle; stalls FETCH/MEMRD/MEMWR
//   pcen..aluop  datapath enables / selects
//   illegal_op   one-cycle pulse when DECODE sees an unknown opcode
//   state_dbg    current state
//
// state   | meaning
// FETCH   | read instruction at PC, PC+4 (waits on mem_ready)
// DECODE  | register read, branch target into ALUOut, dispatch on op
// MEMADR  | effective address for lw/sw
// MEMRD   | data read at ALUOut (waits on mem_ready)
// MEMWB   | load data to rt
// MEMWR   | data write at ALUOut (waits on mem_ready)
// RTYPEEX | R-type ALU operation
// ALUWB   | ALU result to rd
// BRANCH  | compare rs/rt, conditional PC load from ALUOut
// ADDIEX  | rs + signext imm
// ORIEX   | rs | imm
// IMMWB   | immediate result to rt
// JUMP    | PC load from jump target
module mc_controller
  import mips_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pcen,
  output logic               iord,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [1:0]         aluop,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_dbg
);

  state_t state;
  state_t state_next;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    illegal_op = 1'b0;
    case (state)
      S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_RTYPE:       state_next = S_RTYPEEX;
          OP_LW, OP_SW:   state_next = S_MEMADR;
          OP_BEQ, OP_BNE: state_next = S_BRANCH;
          OP_ADDI:        state_next = S_ADDIEX;
          OP_ORI:         state_next = S_ORIEX;
          OP_J:           state_next = S_JUMP;
          default: begin
            state_next = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      // op is stable here; anything other than lw/sw cannot reach MEMADR
      // normally, so it just abandons the instruction
      S_MEMADR: begin
        if (op == OP_LW)      state_next = S_MEMRD;
        else if (op == OP_SW) state_next = S_MEMWR;
        else                  state_next = S_FETCH;
      end
      S_MEMRD:   state_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_next = mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: state_next = S_ALUWB;
      S_ADDIEX:  state_next = S_IMMWB;
      S_ORIEX:   state_next = S_IMMWB;
      default:   state_next = S_FETCH;
    endcase
  end

  mc_ctrl_outdec u_outdec (
    .state     (state),
    .mem_ready (mem_ready),
    .zero      (zero),
    .op        (op),
    .pcen      (pcen),
    .iord      (iord),
    .memwrite  (memwrite),
    .irwrite   (irwrite),
    .regdst    (regdst),
    .memtoreg  (memtoreg),
    .regwrite  (regwrite),
    .alusrca   (alusrca),
    .alusrcb   (alusrcb),
    .pcsrc     (pcsrc),
    .aluop     (aluop)
  );

  assign state_dbg = STATE_W'(state);

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller. The reference model describes each instruction
// as a list of named steps; wait steps repeat while mem_ready is low.
module tb_mc_controller;
  import mips_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic       illegal_op;
  logic [3:0] state_dbg;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mc_controller #(.STATE_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pcen       (pcen),
    .iord       (iord),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .aluop      (aluop),
    .illegal_op (illegal_op),
    .state_dbg  (state_dbg)
  );

  // model position: instruction opcode and step index within it
  logic [5:0] cur_op;
  int         k;

  logic       last_pcen, last_iord, last_regwrite, last_memwrite, last_regdst;
  logic       last_illegal, last_irwrite;
  logic [1:0] last_pcsrc;

  function automatic string step_name(input logic [5:0] o, input int idx);
    string s[$];
    s.push_back("FETCH");
    s.push_back("DECODE");
    case (o)
      6'b100011: begin s.push_back("MEMADR"); s.push_back("MEMRD"); s.push_back("MEMWB"); end
      6'b101011: begin s.push_back("MEMADR"); s.push_back("MEMWR"); end
      6'b000000: begin s.push_back("RTYPEEX"); s.push_back("ALUWB"); end
      6'b000100, 6'b000101: s.push_back("BRANCH");
      6'b001000: begin s.push_back("ADDIEX"); s.push_back("IMMWB"); end
      6'b001101: begin s.push_back("ORIEX"); s.push_back("IMMWB"); end
      6'b000010: s.push_back("JUMP");
      default: ;
    endcase
    if (idx < s.size()) return s[idx];
    return "";
  endfunction

  function automatic int base_latency(input logic [5:0] o);
    case (o)
      6'b000100, 6'b000101, 6'b000010: return 3;
      6'b000000, 6'b101011, 6'b001000, 6'b001101: return 4;
      6'b100011: return 5;
      default: return 2;
    endcase
  endfunction

  function automatic logic [3:0] state_of(input string nm);
    if (nm == "FETCH")   return S_FETCH;
    if (nm == "DECODE")  return S_DECODE;
    if (nm == "MEMADR")  return S_MEMADR;
    if (nm == "MEMRD")   return S_MEMRD;
    if (nm == "MEMWB")   return S_MEMWB;
    if (nm == "MEMWR")   return S_MEMWR;
    if (nm == "RTYPEEX") return S_RTYPEEX;
    if (nm == "ALUWB")   return S_ALUWB;
    if (nm == "BRANCH")  return S_BRANCH;
    if (nm == "ADDIEX")  return S_ADDIEX;
    if (nm == "ORIEX")   return S_ORIEX;
    if (nm == "IMMWB")   return S_IMMWB;
    if (nm == "JUMP")    return S_JUMP;
    return 4'hf;
  endfunction

  // {pcen,iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,aluop,illegal_op}
  function automatic logic [14:0] exp_outs(input string nm, input logic [5:0] o,
                                           input bit mr, input bit z);
    logic pe, io, mw, iw, rd, mt, rw, aa, il;
    logic [1:0] ab, ps, ao;
    pe = 0; io = 0; mw = 0; iw = 0; rd = 0; mt = 0; rw = 0; aa = 0; il = 0;
    ab = 2'b00; ps = 2'b00; ao = 2'b00;
    if (nm == "FETCH") begin ab = 2'b01; iw = mr; pe = mr; end
    else if (nm == "DECODE") begin
      ab = 2'b11;
      il = !(o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                       6'b000101, 6'b001000, 6'b001101, 6'b000010});
    end
    else if (nm == "MEMADR")  begin aa = 1; ab = 2'b10; end
    else if (nm == "MEMRD")   begin io = 1; end
    else if (nm == "MEMWB")   begin mt = 1; rw = 1; end
    else if (nm == "MEMWR")   begin io = 1; mw = 1; end
    else if (nm == "RTYPEEX") begin aa = 1; ao = 2'b10; end
    else if (nm == "ALUWB")   begin rd = 1; rw = 1; end
    else if (nm == "BRANCH")  begin aa = 1; ao = 2'b01; ps = 2'b01; pe = z ^ (o == 6'b000101); end
    else if (nm == "ADDIEX")  begin aa = 1; ab = 2'b10; end
    else if (nm == "ORIEX")   begin aa = 1; ab = 2'b10; ao = 2'b11; end
    else if (nm == "IMMWB")   begin rw = 1; end
    else if (nm == "JUMP")    begin ps = 2'b10; pe = 1; end
    return {pe, io, mw, iw, rd, mt, rw, aa, ab, ps, ao, il};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // inputs change 1 time unit after the rising edge, outputs sampled mid-cycle
  task automatic do_cycle(input bit mr, input bit z, output bit stayed, output bit done);
    string nm;
    logic [14:0] eo, oo;
    mem_ready = mr;
    zero      = z;
    op        = cur_op;
    #4;
    nm = step_name(cur_op, k);
    eo = exp_outs(nm, cur_op, mr, z);
    oo = {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
          alusrcb, pcsrc, aluop, illegal_op};
    check({"outs@", nm}, 32'(oo), 32'(eo));
    check({"state@", nm}, 32'(state_dbg), 32'(state_of(nm)));
    last_pcen = pcen; last_iord = iord; last_regwrite = regwrite;
    last_memwrite = memwrite; last_regdst = regdst; last_illegal = illegal_op;
    last_irwrite = irwrite; last_pcsrc = pcsrc;
    @(posedge clk);
    #1;
    stayed = ((nm == "FETCH" || nm == "MEMRD" || nm == "MEMWR") && !mr);
    done = 1'b0;
    if (!stayed) k++;
    if (step_name(cur_op, k) == "") begin
      k = 0;
      done = 1'b1;
    end
  endtask

  // mrmode: 0 ready always, 1 random, 2 low for stall_n cycles in MEMRD/MEMWR
  // zmode: 0/1 fixed zero flag, 2 random
  task automatic run_instr(input logic [5:0] o, input int zmode, input int mrmode,
                           input int stall_n, output int cycles, output int rw_mask,
                           output int mw_count, output int ill_count);
    bit mr, z, stayed, done;
    int stall_left, waits;
    string nm;
    cur_op = o; k = 0; cycles = 0; rw_mask = 0; mw_count = 0; ill_count = 0;
    waits = 0; stall_left = stall_n; done = 1'b0;
    while (!done && cycles < 60) begin
      nm = step_name(cur_op, k);
      if (mrmode == 0) mr = 1'b1;
      else if (mrmode == 1) mr = ($urandom_range(0, 3) != 0);
      else begin
        mr = !((nm == "MEMRD" || nm == "MEMWR") && stall_left > 0);
        if (!mr) stall_left--;
      end
      z = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
      do_cycle(mr, z, stayed, done);
      if (last_regwrite) rw_mask |= (1 << cycles);
      if (last_memwrite) mw_count++;
      if (last_illegal) ill_count++;
      if (stayed) waits++;
      cycles++;
    end
    check("instr_done", 32'(done), 32'd1);
    check("latency", cycles, base_latency(o) + waits);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, rwm, mwc, ilc;
    bit st, dn;
    logic [5:0] rop;
    logic [5:0] legal_ops [8];
    legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                  6'b000101, 6'b001000, 6'b001101, 6'b000010};

    reset = 1'b1; op = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    cur_op = 6'd0; k = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(state_dbg), 32'(S_FETCH));
    check("reset_regwrite", 32'(regwrite), 32'd0);
    reset = 1'b0;

    // FETCH stall: no IR/PC load, no advance
    do_cycle(1'b0, 1'b0, st, dn);
    check("fetch_stall_irwrite", 32'(last_irwrite), 32'd0);
    check("fetch_stall_pcen", 32'(last_pcen), 32'd0);
    check("fetch_stall_state", 32'(state_dbg), 32'(S_FETCH));

    // lw, memory always ready
    run_instr(6'b100011, 0, 0, 0, cyc, rwm, mwc, ilc);
    check("lw_cycles", cyc, 5);
    check("lw_regwrite_only_c5", rwm, 32'b10000);

    // sw with two stall cycles in MEMWR
    run_instr(6'b101011, 0, 2, 2, cyc, rwm, mwc, ilc);
    check("sw_cycles", cyc, 6);
    check("sw_memwrite_held", mwc, 3);
    check("sw_back_to_fetch", 32'(state_dbg), 32'(S_FETCH));

    // branch decisions (BRANCH is the last step, so last_pcen is its value)
    run_instr(6'b000100, 1, 0, 0, cyc, rwm, mwc, ilc);
    check("beq_z1_pcen", 32'(last_pcen), 32'd1);
    run_instr(6'b000100, 0, 0, 0, cyc, rwm, mwc, ilc);
    check("beq_z0_pcen", 32'(last_pcen), 32'd0);
    run_instr(6'b000101, 0, 0, 0, cyc, rwm, mwc, ilc);
    check("bne_z0_pcen", 32'(last_pcen), 32'd1);
    run_instr(6'b000101, 1, 0, 0, cyc, rwm, mwc, ilc);
    check("bne_z1_pcen", 32'(last_pcen), 32'd0);

    // ori: last step IMMWB writes rt
    run_instr(6'b001101, 0, 0, 0, cyc, rwm, mwc, ilc);
    check("ori_immwb_regwrite", 32'(last_regwrite), 32'd1);
    check("ori_immwb_regdst", 32'(last_regdst), 32'd0);

    // jump
    run_instr(6'b000010, 0, 0, 0, cyc, rwm, mwc, ilc);
    check("j_cycles", cyc, 3);
    check("j_pcen", 32'(last_pcen), 32'd1);
    check("j_pcsrc", 32'(last_pcsrc), 32'd2);

    // illegal opcode
    run_instr(6'b111111, 0, 0, 0, cyc, rwm, mwc, ilc);
    check("illegal_cycles", cyc, 2);
    check("illegal_pulse_count", ilc, 1);

    // reset while a lw sits in MEMRD
    cur_op = 6'b100011; k = 0; rwm = 0;
    do_cycle(1'b1, 1'b0, st, dn); if (last_regwrite) rwm++;
    do_cycle(1'b1, 1'b0, st, dn); if (last_regwrite) rwm++;
    do_cycle(1'b1, 1'b0, st, dn); if (last_regwrite) rwm++;
    do_cycle(1'b0, 1'b0, st, dn); if (last_regwrite) rwm++;
    check("midlw_in_memrd", 32'(state_dbg), 32'(S_MEMRD));
    reset = 1'b1; mem_ready = 1'b1;
    #4;
    if (regwrite) rwm++;
    @(posedge clk);
    #1;
    reset = 1'b0; mem_ready = 1'b0; k = 0;
    #1;
    check("midlw_reset_state", 32'(state_dbg), 32'(S_FETCH));
    check("midlw_reset_iord", 32'(iord), 32'd0);
    check("midlw_reset_regwrite", 32'(regwrite), 32'd0);
    check("midlw_no_regwrite_seen", rwm, 0);
    @(posedge clk);
    #1;

    // randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) rop = 6'($urandom_range(0, 63));
      else rop = legal_ops[$urandom_range(0, 7)];
      run_instr(rop, 2, 1, 0, cyc, rwm, mwc, ilc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
